// File: rtl/sayuru_arb_pkg.sv
// sayuru_arb_pkg
// Shared types for the sayuru two-master port arbiter.
//   state_t                 : arbiter FSM states (ARB = free choice, HOLD = selection frozen)
//   owner_t                 : 1-bit master ID recorded per granted transaction
//   MAX_OUTSTANDING_DEFAULT : default owner FIFO depth
package sayuru_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } state_t;

   typedef logic owner_t;

   localparam int MAX_OUTSTANDING_DEFAULT = 4;

endpackage

// File: rtl/sayuru_owner_fifo.sv
// sayuru_owner_fifo
// In-order FIFO of owner IDs, one entry per granted downstream transaction.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_id (ignored while full)
//   push_id    : owner of the transaction just granted
//   pop        : retire the head entry (ignored while empty)
//   full/empty : occupancy flags
//   head       : owner of the oldest outstanding transaction
// Pointers carry one extra wrap bit, so their difference is the occupancy
// count and distinguishes full from empty without a separate counter.
module sayuru_owner_fifo
   import sayuru_arb_pkg::*;
#(
   parameter int DEPTH = MAX_OUTSTANDING_DEFAULT
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  owner_t push_id,
   input  logic   pop,
   output logic   full,
   output logic   empty,
   output owner_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   owner_t        mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
   end

endmodule

// File: rtl/sayuru_port_arbiter.sv
// sayuru_port_arbiter
// Round-robin arbiter sharing one req/gnt/rvalid slave port between two
// masters (typically instruction fetch on m0, data on m1).
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   mN_data_*                : master N request fields in, gnt/rvalid/rdata out
//   out_data_*               : downstream request fields out, gnt/rvalid/rdata in
//   m0_gnt_count/m1_gnt_count: free-running grant counters (wrap at 2^32)
//   protocol_err_o           : sticky, set by an rvalid with nothing outstanding
//   dbg_state, dbg_prio      : FSM state and round-robin pointer for observation
//
// Handshake: a request transfers in the cycle where req and gnt are both high;
// the requester keeps req and its fields stable until then. Each transfer
// returns exactly one rvalid, in order, at least one cycle after its gnt.
module sayuru_port_arbiter
   import sayuru_arb_pkg::*;
#(
   parameter int ADDR_WIDTH      = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,

   input  logic                    m0_data_req_i,
   output logic                    m0_data_gnt_o,
   output logic                    m0_data_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   m0_data_addr_i,
   input  logic                    m0_data_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_data_be_i,
   input  logic [DATA_WIDTH-1:0]   m0_data_wdata_i,
   output logic [DATA_WIDTH-1:0]   m0_data_rdata_o,

   input  logic                    m1_data_req_i,
   output logic                    m1_data_gnt_o,
   output logic                    m1_data_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   m1_data_addr_i,
   input  logic                    m1_data_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_data_be_i,
   input  logic [DATA_WIDTH-1:0]   m1_data_wdata_i,
   output logic [DATA_WIDTH-1:0]   m1_data_rdata_o,

   output logic                    out_data_req_o,
   input  logic                    out_data_gnt_i,
   input  logic                    out_data_rvalid_i,
   output logic [ADDR_WIDTH-1:0]   out_data_addr_o,
   output logic                    out_data_we_o,
   output logic [DATA_WIDTH/8-1:0] out_data_be_o,
   output logic [DATA_WIDTH-1:0]   out_data_wdata_o,
   input  logic [DATA_WIDTH-1:0]   out_data_rdata_i,

   output logic [31:0]             m0_gnt_count,
   output logic [31:0]             m1_gnt_count,
   output logic                    protocol_err_o,

   output state_t                  dbg_state,
   output owner_t                  dbg_prio
);

   state_t state_q, state_d;
   owner_t prio_q, prio_d;
   owner_t sel_q, sel_d;

   owner_t winner;
   logic   winner_valid;
   owner_t sel;
   logic   sel_req;
   logic   grant;
   logic   fifo_full;
   logic   fifo_empty;
   owner_t fifo_head;
   logic   pop;

   // ARB-state choice: the round-robin pointer only matters on contention.
   always_comb begin
      winner_valid = m0_data_req_i || m1_data_req_i;
      if (m0_data_req_i && m1_data_req_i) winner = prio_q;
      else if (m1_data_req_i)             winner = 1'b1;
      else                                winner = 1'b0;
   end

   // In HOLD the choice is frozen so a waiting request cannot be swapped
   // for the other master's while the slave is still deciding.
   always_comb begin
      if (state_q == HOLD) begin
         sel     = sel_q;
         sel_req = sel_q ? m1_data_req_i : m0_data_req_i;
      end else begin
         sel     = winner;
         sel_req = winner_valid;
      end
   end

   // A full owner FIFO blocks forwarding; a pop in the same cycle does not
   // bypass this, the freed slot is usable from the next cycle.
   assign out_data_req_o   = sel_req && !fifo_full;
   assign grant            = out_data_req_o && out_data_gnt_i;
   assign out_data_addr_o  = sel ? m1_data_addr_i  : m0_data_addr_i;
   assign out_data_we_o    = sel ? m1_data_we_i    : m0_data_we_i;
   assign out_data_be_o    = sel ? m1_data_be_i    : m0_data_be_i;
   assign out_data_wdata_o = sel ? m1_data_wdata_i : m0_data_wdata_i;

   assign m0_data_gnt_o = grant && (sel == 1'b0);
   assign m1_data_gnt_o = grant && (sel == 1'b1);

   // Responses are steered by the oldest outstanding owner; an rvalid with
   // nothing outstanding is dropped and flagged.
   assign pop              = out_data_rvalid_i && !fifo_empty;
   assign m0_data_rvalid_o = pop && (fifo_head == 1'b0);
   assign m1_data_rvalid_o = pop && (fifo_head == 1'b1);
   assign m0_data_rdata_o  = out_data_rdata_i;
   assign m1_data_rdata_o  = out_data_rdata_i;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      sel_d   = sel_q;
      if (grant) prio_d = ~sel;
      case (state_q)
         ARB: begin
            if (out_data_req_o && !out_data_gnt_i) begin
               sel_d   = winner;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Leaving on a dropped request (a protocol violation by the
            // master) releases the port without recording a transaction.
            if (grant || !sel_req) state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ARB;
         prio_q         <= 1'b0;
         sel_q          <= 1'b0;
         m0_gnt_count   <= '0;
         m1_gnt_count   <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         sel_q   <= sel_d;
         if (m0_data_gnt_o) m0_gnt_count <= m0_gnt_count + 32'd1;
         if (m1_data_gnt_o) m1_gnt_count <= m1_gnt_count + 32'd1;
         if (out_data_rvalid_i && fifo_empty) protocol_err_o <= 1'b1;
      end
   end

   assign dbg_state = state_q;
   assign dbg_prio  = prio_q;

   sayuru_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (grant),
      .push_id (sel),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

endmodule

// File: tb/tb_sayuru_port_arbiter.sv
// tb_sayuru_port_arbiter
// Directed bench for sayuru_port_arbiter (ADDR 16, DATA 32, 4 outstanding).
// Inputs change 1 time unit after the rising edge and outputs are compared
// 1 unit later, well clear of the next edge.
module tb_sayuru_port_arbiter;
   import sayuru_arb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m0_gnt, m0_rvalid, m0_we;
   logic [15:0] m0_addr;
   logic [3:0]  m0_be;
   logic [31:0] m0_wdata, m0_rdata;
   logic        m1_req, m1_gnt, m1_rvalid, m1_we;
   logic [15:0] m1_addr;
   logic [3:0]  m1_be;
   logic [31:0] m1_wdata, m1_rdata;
   logic        out_req, out_gnt, out_rvalid, out_we;
   logic [15:0] out_addr;
   logic [3:0]  out_be;
   logic [31:0] out_wdata, out_rdata;
   logic [31:0] m0_cnt, m1_cnt;
   logic        perr;
   state_t      dbg_state;
   owner_t      dbg_prio;

   int n_checks = 0;
   int n_fails  = 0;

   sayuru_port_arbiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .m0_data_req_i     (m0_req),
      .m0_data_gnt_o     (m0_gnt),
      .m0_data_rvalid_o  (m0_rvalid),
      .m0_data_addr_i    (m0_addr),
      .m0_data_we_i      (m0_we),
      .m0_data_be_i      (m0_be),
      .m0_data_wdata_i   (m0_wdata),
      .m0_data_rdata_o   (m0_rdata),
      .m1_data_req_i     (m1_req),
      .m1_data_gnt_o     (m1_gnt),
      .m1_data_rvalid_o  (m1_rvalid),
      .m1_data_addr_i    (m1_addr),
      .m1_data_we_i      (m1_we),
      .m1_data_be_i      (m1_be),
      .m1_data_wdata_i   (m1_wdata),
      .m1_data_rdata_o   (m1_rdata),
      .out_data_req_o    (out_req),
      .out_data_gnt_i    (out_gnt),
      .out_data_rvalid_i (out_rvalid),
      .out_data_addr_o   (out_addr),
      .out_data_we_o     (out_we),
      .out_data_be_o     (out_be),
      .out_data_wdata_o  (out_wdata),
      .out_data_rdata_i  (out_rdata),
      .m0_gnt_count      (m0_cnt),
      .m1_gnt_count      (m1_cnt),
      .protocol_err_o    (perr),
      .dbg_state         (dbg_state),
      .dbg_prio          (dbg_prio)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic idle();
      m0_req = 1'b0; m1_req = 1'b0;
      out_gnt = 1'b0; out_rvalid = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_req"},  32'(out_req),   32'd0);
      chk({tag, "_m0_gnt"},   32'(m0_gnt),    32'd0);
      chk({tag, "_m1_gnt"},   32'(m1_gnt),    32'd0);
      chk({tag, "_m0_rv"},    32'(m0_rvalid), 32'd0);
      chk({tag, "_m1_rv"},    32'(m1_rvalid), 32'd0);
      chk({tag, "_m0_cnt"},   m0_cnt,         32'd0);
      chk({tag, "_m1_cnt"},   m1_cnt,         32'd0);
      chk({tag, "_perr"},     32'(perr),      32'd0);
      chk({tag, "_state"},    32'(dbg_state), 32'(ARB));
      chk({tag, "_prio"},     32'(dbg_prio),  32'd0);
      chk({tag, "_addr_m0"},  32'(out_addr),  32'(m0_addr));
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      m0_addr = 16'h1111; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'hA0A0_A0A0;
      m1_addr = 16'h2222; m1_we = 1'b1; m1_be = 4'h3; m1_wdata = 32'hB1B1_B1B1;
      out_rdata = 32'h0;

      // Reset state.
      #3;
      chk_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Both masters requesting, slave grants every cycle, rvalid 1 cycle later.
      for (int k = 0; k < 4; k++) begin
         cyc();
         m0_req = 1'b1; m1_req = 1'b1; out_gnt = 1'b1;
         out_rvalid = (k >= 1);
         out_rdata = 32'h1000 + 32'(k);
         settle();
         chk($sformatf("rr_m0_gnt%0d", k), 32'(m0_gnt), 32'((k % 2) == 0));
         chk($sformatf("rr_m1_gnt%0d", k), 32'(m1_gnt), 32'((k % 2) == 1));
         chk($sformatf("rr_addr%0d", k), 32'(out_addr), (k % 2 == 0) ? 32'h1111 : 32'h2222);
         if (k >= 1) begin
            chk($sformatf("rr_m0_rv%0d", k), 32'(m0_rvalid), 32'(((k - 1) % 2) == 0));
            chk($sformatf("rr_m1_rv%0d", k), 32'(m1_rvalid), 32'(((k - 1) % 2) == 1));
         end
      end
      cyc();
      idle();
      out_rvalid = 1'b1;
      settle();
      chk("rr_last_m1_rv", 32'(m1_rvalid), 32'd1);
      chk("rr_last_m0_rv", 32'(m0_rvalid), 32'd0);
      chk("rr_m0_cnt", m0_cnt, 32'd2);
      chk("rr_m1_cnt", m1_cnt, 32'd2);
      chk("rr_perr", 32'(perr), 32'd0);

      // Single m0 read, rvalid two cycles after the grant.
      cyc();
      idle();
      m0_req = 1'b1; m0_addr = 16'h0040; out_gnt = 1'b1;
      settle();
      chk("single_out_req", 32'(out_req), 32'd1);
      chk("single_addr", 32'(out_addr), 32'h0040);
      chk("single_m0_gnt", 32'(m0_gnt), 32'd1);
      chk("single_m1_gnt", 32'(m1_gnt), 32'd0);
      cyc();
      idle();
      cyc();
      out_rvalid = 1'b1; out_rdata = 32'hDEAD_BEEF;
      settle();
      chk("single_m0_rv", 32'(m0_rvalid), 32'd1);
      chk("single_m1_rv", 32'(m1_rvalid), 32'd0);
      chk("single_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("single_m0_cnt", m0_cnt, 32'd3);

      // m1 waits in HOLD while the slave stalls; m0 must not preempt it.
      cyc();
      idle();
      m1_req = 1'b1; m1_addr = 16'h0200;
      settle();
      chk("hold_req", 32'(out_req), 32'd1);
      chk("hold_addr0", 32'(out_addr), 32'h0200);
      chk("hold_m1_gnt0", 32'(m1_gnt), 32'd0);
      cyc();
      m0_req = 1'b1; m0_addr = 16'h0300;
      settle();
      chk("hold_state", 32'(dbg_state), 32'(HOLD));
      chk("hold_addr1", 32'(out_addr), 32'h0200);
      chk("hold_m0_gnt1", 32'(m0_gnt), 32'd0);
      cyc();
      settle();
      chk("hold_addr2", 32'(out_addr), 32'h0200);
      cyc();
      out_gnt = 1'b1;
      settle();
      chk("hold_m1_gnt", 32'(m1_gnt), 32'd1);
      chk("hold_m0_gnt", 32'(m0_gnt), 32'd0);
      cyc();
      m1_req = 1'b0;
      settle();
      chk("after_hold_state", 32'(dbg_state), 32'(ARB));
      chk("after_hold_m0_gnt", 32'(m0_gnt), 32'd1);
      chk("after_hold_addr", 32'(out_addr), 32'h0300);
      cyc();
      idle();
      out_rvalid = 1'b1;
      settle();
      chk("hold_rv_m1", 32'(m1_rvalid), 32'd1);
      cyc();
      settle();
      chk("hold_rv_m0", 32'(m0_rvalid), 32'd1);
      chk("hold_m0_cnt", m0_cnt, 32'd4);
      chk("hold_m1_cnt", m1_cnt, 32'd3);

      // Fill the owner FIFO: the fifth request must be blocked until a pop.
      for (int k = 0; k < 4; k++) begin
         cyc();
         idle();
         m0_req = 1'b1; out_gnt = 1'b1;
         settle();
         chk($sformatf("fill_gnt%0d", k), 32'(m0_gnt), 32'd1);
      end
      cyc();
      out_rvalid = 1'b1;
      settle();
      chk("full_out_req", 32'(out_req), 32'd0);
      chk("full_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("full_pop_rv", 32'(m0_rvalid), 32'd1);
      cyc();
      out_rvalid = 1'b0;
      settle();
      chk("freed_out_req", 32'(out_req), 32'd1);
      chk("freed_m0_gnt", 32'(m0_gnt), 32'd1);
      cyc();
      idle();
      m0_addr = 16'h1111;
      settle();
      chk("fill_m0_cnt", m0_cnt, 32'd9);
      chk("fill_prio", 32'(dbg_prio), 32'd1);

      // Asynchronous reset with transactions outstanding.
      cyc();
      rst_n = 1'b0;
      settle();
      chk_reset_outputs("midrst");
      cyc();
      rst_n = 1'b1;

      // A late rvalid finds the FIFO empty: dropped and flagged, and sticky.
      cyc();
      out_rvalid = 1'b1;
      settle();
      chk("late_m0_rv", 32'(m0_rvalid), 32'd0);
      chk("late_m1_rv", 32'(m1_rvalid), 32'd0);
      cyc();
      out_rvalid = 1'b0;
      settle();
      chk("perr_set", 32'(perr), 32'd1);
      cyc();
      cyc();
      settle();
      chk("perr_sticky", 32'(perr), 32'd1);
      cyc();
      rst_n = 1'b0;
      settle();
      chk("perr_cleared", 32'(perr), 32'd0);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
